// File: rtl/control_sequencer.sv
// Hardwired control-step sequencer: fetch (T0-T2) plus per-opcode execute steps,
// driving register-field selects for select/encode and the datapath/memory strobes.
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            GRA,
    output logic            GRB,
    output logic            GRC,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic            Cout,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Read,
    output logic            Write,
    output logic [ALUW-1:0] alu_op,
    output logic            run,
    output logic            illegal
);

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(2);
    localparam logic [ALUW-1:0] ALU_OR  = ALUW'(3);

    state_t state, next_state;

    logic [OPW-1:0]  opcode;
    logic            ir_unused;
    logic            is_alu, is_addi, is_ba, is_ld, is_st;
    logic [ALUW-1:0] alu_sel;

    assign opcode    = ir[31 -: OPW];
    assign ir_unused = ^ir[31-OPW:0];

    // Opcode classes: register ALU ops, immediate add, and the base+offset group (ldi/ld/st)
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
    assign is_addi = (opcode == OP_ADDI);
    assign is_ld   = (opcode == OP_LD);
    assign is_st   = (opcode == OP_ST);
    assign is_ba   = is_ld || is_st || (opcode == OP_LDI);

    always_comb begin
        alu_sel = ALU_ADD;
        case (opcode)
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            default: alu_sel = ALU_ADD;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= RST;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
        Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
        Read = 1'b0; Write = 1'b0;
        alu_op  = ALU_ADD;
        run     = 1'b1;
        illegal = 1'b0;

        case (state)
            RST: next_state = T0;
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                next_state = T1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                if (mem_ready) next_state = T2;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                next_state = T3;
            end
            T3: begin
                if (is_alu || is_addi) begin
                    GRB = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    next_state = T4;
                end else if (is_ba) begin
                    GRB = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    next_state = T4;
                end else if (opcode == OP_NOP) begin
                    next_state = T0;
                end else if (opcode == OP_HALT) begin
                    next_state = HALT;
                end else begin
                    illegal    = 1'b1;
                    next_state = T0;
                end
            end
            T4: begin
                Zin = 1'b1;
                if (is_alu) begin
                    GRC = 1'b1; Rout = 1'b1; alu_op = alu_sel;
                end else begin
                    Cout = 1'b1;
                end
                next_state = T5;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_ld || is_st) begin
                    MARin = 1'b1;
                    next_state = T6;
                end else begin
                    GRA = 1'b1; Rin = 1'b1;
                    next_state = T0;
                end
            end
            T6: begin
                MDRin = 1'b1;
                if (is_ld) begin
                    Read = 1'b1;
                    if (mem_ready) next_state = T7;
                end else begin
                    GRA = 1'b1; Rout = 1'b1;
                    next_state = T7;
                end
            end
            T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                    next_state = T0;
                end else begin
                    Write = 1'b1;
                    if (mem_ready) next_state = T0;
                end
            end
            HALT: run = 1'b0;
            default: next_state = RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a per-opcode table of expected control steps
// is replayed against the DUT with random memory stalls, plus directed halt/abort cases.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir;
    logic        mem_ready;
    logic GRA, GRB, GRC, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
    logic MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Read, Write;
    logic [3:0] alu_op;
    logic run, illegal;

    int nvec = 0;
    int nerr = 0;

    control_sequencer #(.OPW(5), .ALUW(4)) dut (
        .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
        .GRA(GRA), .GRB(GRB), .GRC(GRC), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Read(Read), .Write(Write), .alu_op(alu_op),
        .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    logic [24:0] obs;
    assign obs = {GRA, GRB, GRC, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin,
                  MDRin, MDRout, IRin, Yin, Zin, Zlowout, Read, Write, alu_op, run, illegal};

    localparam logic [24:0] M_GRA   = 25'(1) << 24;
    localparam logic [24:0] M_GRB   = 25'(1) << 23;
    localparam logic [24:0] M_GRC   = 25'(1) << 22;
    localparam logic [24:0] M_RIN   = 25'(1) << 21;
    localparam logic [24:0] M_ROUT  = 25'(1) << 20;
    localparam logic [24:0] M_BAOUT = 25'(1) << 19;
    localparam logic [24:0] M_COUT  = 25'(1) << 18;
    localparam logic [24:0] M_PCOUT = 25'(1) << 17;
    localparam logic [24:0] M_PCIN  = 25'(1) << 16;
    localparam logic [24:0] M_INCPC = 25'(1) << 15;
    localparam logic [24:0] M_MARIN = 25'(1) << 14;
    localparam logic [24:0] M_MDRIN = 25'(1) << 13;
    localparam logic [24:0] M_MDROUT= 25'(1) << 12;
    localparam logic [24:0] M_IRIN  = 25'(1) << 11;
    localparam logic [24:0] M_YIN   = 25'(1) << 10;
    localparam logic [24:0] M_ZIN   = 25'(1) << 9;
    localparam logic [24:0] M_ZLOW  = 25'(1) << 8;
    localparam logic [24:0] M_READ  = 25'(1) << 7;
    localparam logic [24:0] M_WRITE = 25'(1) << 6;
    localparam logic [24:0] M_RUN   = 25'(1) << 1;
    localparam logic [24:0] M_ILL   = 25'(1) << 0;

    typedef struct {
        logic [24:0] v;
        bit          mwait;
    } step_t;

    step_t plan[$];

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void add_step(input logic [24:0] v, input bit w);
        plan.push_back('{v: v, mwait: w});
    endfunction

    // Expected step sequence for one instruction, straight from the opcode table
    function automatic void build_plan(input logic [4:0] op);
        logic [24:0] aluv;
        plan.delete();
        add_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN, 1'b0);
        add_step(M_ZLOW | M_PCIN | M_READ | M_MDRIN | M_RUN, 1'b1);
        add_step(M_MDROUT | M_IRIN | M_RUN, 1'b0);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                aluv = 25'(op - 5'b00011) << 2;
                add_step(M_GRB | M_ROUT | M_YIN | M_RUN, 1'b0);
                add_step(M_GRC | M_ROUT | M_ZIN | aluv | M_RUN, 1'b0);
                add_step(M_ZLOW | M_GRA | M_RIN | M_RUN, 1'b0);
            end
            5'b01100: begin
                add_step(M_GRB | M_ROUT | M_YIN | M_RUN, 1'b0);
                add_step(M_COUT | M_ZIN | M_RUN, 1'b0);
                add_step(M_ZLOW | M_GRA | M_RIN | M_RUN, 1'b0);
            end
            5'b00001: begin
                add_step(M_GRB | M_BAOUT | M_YIN | M_RUN, 1'b0);
                add_step(M_COUT | M_ZIN | M_RUN, 1'b0);
                add_step(M_ZLOW | M_GRA | M_RIN | M_RUN, 1'b0);
            end
            5'b00000: begin
                add_step(M_GRB | M_BAOUT | M_YIN | M_RUN, 1'b0);
                add_step(M_COUT | M_ZIN | M_RUN, 1'b0);
                add_step(M_ZLOW | M_MARIN | M_RUN, 1'b0);
                add_step(M_READ | M_MDRIN | M_RUN, 1'b1);
                add_step(M_MDROUT | M_GRA | M_RIN | M_RUN, 1'b0);
            end
            5'b00010: begin
                add_step(M_GRB | M_BAOUT | M_YIN | M_RUN, 1'b0);
                add_step(M_COUT | M_ZIN | M_RUN, 1'b0);
                add_step(M_ZLOW | M_MARIN | M_RUN, 1'b0);
                add_step(M_GRA | M_ROUT | M_MDRIN | M_RUN, 1'b0);
                add_step(M_WRITE | M_RUN, 1'b1);
            end
            5'b11010, 5'b11011: add_step(M_RUN, 1'b0);
            default:            add_step(M_ILL | M_RUN, 1'b0);
        endcase
    endfunction

    // Entered and left 1 time unit after a rising edge
    task automatic step_check(input string tag, input logic [24:0] exp, input logic mr);
        mem_ready = mr;
        #2;
        chk(tag, obs, exp);
        @(posedge clock);
        #1;
    endtask

    // Replays the plan; nsteps limits how many steps run (for abort tests)
    task automatic run_instr(input logic [31:0] instr, input int s1, input int s2,
                             input int nsteps);
        int stall;
        string tag;
        build_plan(instr[31:27]);
        for (int i = 0; i < plan.size() && i < nsteps; i++) begin
            tag = $sformatf("op%b_step%0d", instr[31:27], i);
            ir = (i < 2) ? 32'($urandom) : instr;
            if (plan[i].mwait) begin
                stall = (i == 1) ? s1 : s2;
                for (int k = 0; k < stall; k++) begin
                    if (i < 2) ir = 32'($urandom);
                    step_check({tag, "_stall"}, plan[i].v, 1'b0);
                end
                step_check(tag, plan[i].v, 1'b1);
            end else begin
                step_check(tag, plan[i].v, 1'($urandom));
            end
        end
    endtask

    task automatic reset_pulse(input string tag, input int cycles);
        clear = 1'b1;
        #1;
        chk({tag, "_async"}, obs, M_RUN);
        for (int k = 0; k < cycles; k++) begin
            @(posedge clock);
            #1;
            chk({tag, "_held"}, obs, M_RUN);
        end
        clear = 1'b0;
        #1;
        chk({tag, "_rst"}, obs, M_RUN);
        @(posedge clock);
        #1;
    endtask

    function automatic logic [4:0] rand_op();
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == 5'b11011) op = 5'b11010;
        return op;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] instr;
        clear = 1'b1;
        ir = '0;
        mem_ready = 1'b1;
        #1;
        chk("reset_state", obs, M_RUN);
        repeat (3) @(posedge clock);
        #1;
        chk("reset_hold", obs, M_RUN);
        clear = 1'b0;
        #1;
        chk("rst_after_release", obs, M_RUN);
        @(posedge clock);
        #1;

        run_instr(32'h19A00000, 0, 0, 99);
        run_instr({5'b00000, 27'($urandom)}, 0, 3, 99);
        run_instr({5'b00010, 27'($urandom)}, 1, 2, 99);
        run_instr({5'b11111, 27'($urandom)}, 0, 0, 99);
        run_instr({5'b11010, 27'($urandom)}, 2, 0, 99);

        for (int n = 0; n < 80; n++) begin
            instr = {rand_op(), 27'($urandom)};
            run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3), 99);
        end

        run_instr({5'b11011, 27'($urandom)}, 0, 0, 99);
        for (int k = 0; k < 20; k++) begin
            ir = 32'($urandom);
            step_check("halted", '0, 1'($urandom));
        end
        reset_pulse("clear_halt", 1);
        run_instr({5'b00001, 27'($urandom)}, 0, 0, 99);

        instr = {5'b00000, 27'($urandom)};
        run_instr(instr, 0, 0, 6);
        step_check("ld_t6_stall", M_READ | M_MDRIN | M_RUN, 1'b0);
        step_check("ld_t6_stall", M_READ | M_MDRIN | M_RUN, 1'b0);
        mem_ready = 1'b0;
        reset_pulse("clear_ld", 1);
        run_instr({5'b00101, 27'($urandom)}, 1, 0, 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
